// File: rtl/frame_seq_pkg.sv
// Shared types and widths for the frame sequencer slice.
package frame_seq_pkg;

  localparam int PIX_W  = 12;
  localparam int CONT_W = 16;
  localparam int FCNT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sig_edge_det.sv
// Registered edge detector: remembers last cycle's level and flags
// rising/falling transitions combinationally against the current input.
module sig_edge_det
  import frame_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/frame_seq_ctrl.sv
// Sensor-to-imgproc frame sequencer: arms on request, captures whole frames
// only, and emits per-pixel valid plus column/row coordinates.
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 960
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic [PIX_W-1:0]  iDATA,
  input  logic              iSTART,
  input  logic              iSTOP,
  input  logic              iSW,
  output logic [PIX_W-1:0]  oDATA,
  output logic              oDVAL,
  output logic [CONT_W-1:0] oX_Cont,
  output logic [CONT_W-1:0] oY_Cont,
  output logic              oSW,
  output logic              oSOF,
  output logic              oEOF,
  output logic [FCNT_W-1:0] oFrame_Cont,
  output logic              oBusy
);

  seq_state_t state_q, state_d;

  logic fval_rise, fval_fall, lval_rise, lval_fall;
  logic active, frame_end, accept;
  logic [CONT_W-1:0] x_base;

  logic [PIX_W-1:0]  data_q, data_d;
  logic              dval_q, dval_d;
  logic [CONT_W-1:0] xo_q, xo_d, yo_q, yo_d;
  logic [CONT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic              sw_q, sw_d, sof_q, sof_d, eof_q, eof_d;
  logic              stop_pending_q, stop_d;
  logic [FCNT_W-1:0] frame_cnt_q, fcnt_d;

  sig_edge_det u_fval_edge (
    .clk_i  (iCLK),
    .rst_ni (iRST),
    .sig_i  (iFVAL),
    .rise_o (fval_rise),
    .fall_o (fval_fall)
  );

  sig_edge_det u_lval_edge (
    .clk_i  (iCLK),
    .rst_ni (iRST),
    .sig_i  (iLVAL),
    .rise_o (lval_rise),
    .fall_o (lval_fall)
  );

  // A new line always starts counting at column 0, even if the count drifted.
  assign x_base    = lval_rise ? '0 : x_cnt_q;
  assign active    = (state_q == ACTIVE);
  assign frame_end = active && fval_fall;
  assign accept    = active && iFVAL && iLVAL &&
                     (x_base < CONT_W'(WIDTH)) && (y_cnt_q < CONT_W'(HEIGHT));

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iSTART && !iSTOP) state_d = ARMED;
      ARMED: begin
        if (iSTOP)          state_d = IDLE;
        else if (fval_rise) state_d = ACTIVE;
      end
      ACTIVE:  if (fval_fall) state_d = (stop_pending_q || iSTOP) ? IDLE : ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    xo_d   = xo_q;
    yo_d   = yo_q;
    dval_d = accept;
    if (accept) begin
      data_d = iDATA;
      xo_d   = x_base;
      yo_d   = y_cnt_q;
    end

    sof_d  = (state_q == ARMED) && (state_d == ACTIVE);
    eof_d  = frame_end;
    sw_d   = sof_d ? iSW : sw_q;
    fcnt_d = frame_cnt_q;
    if (frame_end) fcnt_d = frame_cnt_q + 1'b1;

    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (sof_d) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (active) begin
      if (lval_fall)   x_cnt_d = '0;
      else if (accept) x_cnt_d = x_base + 1'b1;
      else             x_cnt_d = x_base;
      if (lval_fall && (y_cnt_q < CONT_W'(HEIGHT))) y_cnt_d = y_cnt_q + 1'b1;
    end

    // A stop seen any time during the frame is honoured at its end.
    stop_d = 1'b0;
    if (active && !frame_end) stop_d = stop_pending_q || iSTOP;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      data_q         <= '0;
      dval_q         <= 1'b0;
      xo_q           <= '0;
      yo_q           <= '0;
      x_cnt_q        <= '0;
      y_cnt_q        <= '0;
      sw_q           <= 1'b0;
      sof_q          <= 1'b0;
      eof_q          <= 1'b0;
      stop_pending_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      data_q         <= data_d;
      dval_q         <= dval_d;
      xo_q           <= xo_d;
      yo_q           <= yo_d;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      sw_q           <= sw_d;
      sof_q          <= sof_d;
      eof_q          <= eof_d;
      stop_pending_q <= stop_d;
      frame_cnt_q    <= fcnt_d;
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = xo_q;
  assign oY_Cont     = yo_q;
  assign oSW         = sw_q;
  assign oSOF        = sof_q;
  assign oEOF        = eof_q;
  assign oFrame_Cont = frame_cnt_q;
  assign oBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Bench for frame_seq_ctrl: a hand-derived vector table, scripted frame
// scenarios, and a random run, all checked against a behavioural model.
module tb_frame_seq_ctrl;
  import frame_seq_pkg::*;

  localparam int W = 8;
  localparam int H = 4;

  logic              iCLK = 1'b0;
  logic              iRST, iFVAL, iLVAL, iSTART, iSTOP, iSW;
  logic [PIX_W-1:0]  iDATA;
  logic [PIX_W-1:0]  oDATA;
  logic              oDVAL, oSW, oSOF, oEOF, oBusy;
  logic [CONT_W-1:0] oX_Cont, oY_Cont;
  logic [FCNT_W-1:0] oFrame_Cont;

  int total = 0;
  int bad   = 0;

  // Behavioural model: capture phase flags, current line/column, expected outputs
  bit                mPrevF, mPrevL, mArmed, mCapt, mStopReq;
  int                mCol, mRow;
  logic [PIX_W-1:0]  eData;
  bit                eDval, eSW, eSOF, eEOF, eBusy;
  logic [CONT_W-1:0] eX, eY;
  logic [FCNT_W-1:0] eFrames;

  int dvalCount, sofCount, eofCount, maxX, maxY, pixErr, firstX, firstY, swBad;
  bit watchSw, watchSwVal;

  typedef struct {
    bit [5:0] ctl;
    int       data;
    bit [4:0] flags;
    int       eData;
    int       ex;
    int       ey;
    int       frames;
  } vec_t;

  vec_t vecs[14];

  frame_seq_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iDATA       (iDATA),
    .iSTART      (iSTART),
    .iSTOP       (iSTOP),
    .iSW         (iSW),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oSW         (oSW),
    .oSOF        (oSOF),
    .oEOF        (oEOF),
    .oFrame_Cont (oFrame_Cont),
    .oBusy       (oBusy)
  );

  always #5 iCLK = ~iCLK;

  function automatic vec_t mkVec(input bit [5:0] ctl, input int data, input bit [4:0] flags,
                                 input int ed, input int ex, input int ey, input int frames);
    vec_t v;
    v.ctl = ctl; v.data = data; v.flags = flags;
    v.eData = ed; v.ex = ex; v.ey = ey; v.frames = frames;
    return v;
  endfunction

  // ctl = {rst_n, start, stop, fval, lval, sw}
  task automatic modelStep(input bit [5:0] ctl, input logic [PIX_W-1:0] d);
    bit rst, start, stop, f, l, sw, rise, fall, lfall;
    {rst, start, stop, f, l, sw} = ctl;
    if (!rst) begin
      mPrevF = 0; mPrevL = 0; mArmed = 0; mCapt = 0; mStopReq = 0;
      mCol = 0; mRow = 0;
      eData = '0; eDval = 0; eX = '0; eY = '0; eSW = 0; eSOF = 0; eEOF = 0;
      eFrames = '0; eBusy = 0;
      return;
    end
    rise  = f && !mPrevF;
    fall  = !f && mPrevF;
    lfall = !l && mPrevL;
    eSOF = 0; eEOF = 0; eDval = 0;
    if (mCapt) begin
      if (f && l && mCol < W && mRow < H) begin
        eDval = 1; eData = d; eX = CONT_W'(mCol); eY = CONT_W'(mRow);
        mCol++;
      end
      if (lfall) begin
        mCol = 0;
        if (mRow < H) mRow++;
      end
      if (stop) mStopReq = 1;
      if (fall) begin
        eEOF = 1; eFrames = eFrames + 1;
        mCapt = 0; mArmed = !mStopReq; mStopReq = 0;
      end
    end else if (mArmed) begin
      if (stop) mArmed = 0;
      else if (rise) begin
        mArmed = 0; mCapt = 1; eSOF = 1; eSW = sw; mCol = 0; mRow = 0;
      end
    end else if (start && !stop) begin
      mArmed = 1;
    end
    mPrevF = f;
    mPrevL = l;
    eBusy  = mArmed || mCapt;
  endtask

  task automatic checkOutput(input string name);
    logic [80:0] act, exp;
    act = {oDATA, oDVAL, oX_Cont, oY_Cont, oSW, oSOF, oEOF, oFrame_Cont, oBusy};
    exp = {eData, eDval, eX, eY, eSW, eSOF, eEOF, eFrames, eBusy};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic resetStats();
    dvalCount = 0; sofCount = 0; eofCount = 0; maxX = 0; maxY = 0;
    pixErr = 0; firstX = -1; firstY = -1; swBad = 0;
  endtask

  task automatic applyStimulus(input bit [5:0] ctl, input int data, input string name);
    {iRST, iSTART, iSTOP, iFVAL, iLVAL, iSW} = ctl;
    iDATA = PIX_W'(data);
    modelStep(ctl, PIX_W'(data));
    @(posedge iCLK);
    #1;
    checkOutput(name);
    if (oDVAL) begin
      dvalCount++;
      if (int'(oX_Cont) > maxX) maxX = int'(oX_Cont);
      if (int'(oY_Cont) > maxY) maxY = int'(oY_Cont);
      if (firstX < 0) begin
        firstX = int'(oX_Cont);
        firstY = int'(oY_Cont);
      end
      if (int'(oDATA) != int'(oY_Cont) * W + int'(oX_Cont)) pixErr++;
    end
    if (oSOF) sofCount++;
    if (oEOF) eofCount++;
    if (watchSw && (oSW !== watchSwVal)) swBad++;
  endtask

  // evKind: 0 none, 1 stop pulse, 2 reset pulse at pixel 3 of line evLine
  task automatic runFrame(input int lines, input int pixels, input int gap, input bit swStart,
                          input bit toggleSw, input int evLine, input int evKind);
    bit sw, stp, rn;
    sw = swStart;
    applyStimulus({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sw}, 0, "frame_lead");
    watchSw    = toggleSw;
    watchSwVal = swStart;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < pixels; x++) begin
        if (toggleSw) sw = ~sw;
        stp = (evKind == 1) && (y == evLine) && (x == 3);
        rn  = !((evKind == 2) && (y == evLine) && (x == 3));
        applyStimulus({rn, 1'b0, stp, 1'b1, 1'b1, sw}, y * W + x, "frame_pix");
      end
      for (int g = 0; g < gap; g++)
        applyStimulus({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sw}, 0, "frame_gap");
    end
    applyStimulus({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sw}, 0, "frame_tail");
    watchSw = 0;
  endtask

  initial begin
    bit f, l;
    logic [63:0] got, want;
    iRST = 1'b0; iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iSTOP = 1'b0; iSW = 1'b0;
    iDATA = '0;
    watchSw = 0; watchSwVal = 0;
    resetStats();

    // ctl = {rst_n,start,stop,fval,lval,sw}; flags = {dval,sw,sof,eof,busy}
    vecs[0]  = mkVec(6'b000000, 'h000, 5'b00000, 'h000, 0, 0, 0);
    vecs[1]  = mkVec(6'b110000, 'h000, 5'b00001, 'h000, 0, 0, 0);
    vecs[2]  = mkVec(6'b100000, 'h000, 5'b00001, 'h000, 0, 0, 0);
    vecs[3]  = mkVec(6'b100101, 'h000, 5'b01101, 'h000, 0, 0, 0);
    vecs[4]  = mkVec(6'b100111, 'h011, 5'b11001, 'h011, 0, 0, 0);
    vecs[5]  = mkVec(6'b100110, 'h022, 5'b11001, 'h022, 1, 0, 0);
    vecs[6]  = mkVec(6'b100100, 'h033, 5'b01001, 'h022, 1, 0, 0);
    vecs[7]  = mkVec(6'b100110, 'h044, 5'b11001, 'h044, 0, 1, 0);
    vecs[8]  = mkVec(6'b100000, 'h055, 5'b01011, 'h044, 0, 1, 1);
    vecs[9]  = mkVec(6'b100000, 'h000, 5'b01001, 'h044, 0, 1, 1);
    vecs[10] = mkVec(6'b101000, 'h000, 5'b01000, 'h044, 0, 1, 1);
    vecs[11] = mkVec(6'b111000, 'h000, 5'b01000, 'h044, 0, 1, 1);
    vecs[12] = mkVec(6'b100100, 'h000, 5'b01000, 'h044, 0, 1, 1);
    vecs[13] = mkVec(6'b000000, 'h000, 5'b00000, 'h000, 0, 0, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].ctl, vecs[i].data, "table_model");
      got  = {oDVAL, oSW, oSOF, oEOF, oBusy, 3'b000, oDATA, oX_Cont[3:0], oY_Cont[3:0],
              oFrame_Cont[27:0]};
      want = {vecs[i].flags, 3'b000, PIX_W'(vecs[i].eData), 4'(vecs[i].ex), 4'(vecs[i].ey),
              28'(vecs[i].frames)};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL table_row%0d got=%h want=%h", i, got, want);
      end
    end

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 3; i++)
      applyStimulus({1'b0, 5'($urandom)}, int'($urandom_range(0, 4095)), "reset_hold");
    checkValue("reset_outputs_zero",
               longint'({oDATA, oDVAL, oX_Cont, oY_Cont, oSW, oSOF, oEOF}) +
               longint'(oFrame_Cont) + longint'(oBusy), 0);

    $display("[TB] normal frame");
    applyStimulus({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 0, "normal_start");
    resetStats();
    runFrame(4, 8, 2, 1'b0, 1'b0, -1, 0);
    checkValue("normal_dval_count", dvalCount, 32);
    checkValue("normal_sof_count", sofCount, 1);
    checkValue("normal_eof_count", eofCount, 1);
    checkValue("normal_frame_cont", oFrame_Cont, 1);
    checkValue("normal_pixel_coords", pixErr, 0);

    $display("[TB] mid-frame arm");
    applyStimulus({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 0, "midarm_stop");
    resetStats();
    applyStimulus({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 0, "midarm_lead");
    for (int x = 0; x < 8; x++)
      applyStimulus({1'b1, (x == 3), 1'b0, 1'b1, 1'b1, 1'b0}, x, "midarm_pix");
    for (int g = 0; g < 2; g++)
      applyStimulus({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 0, "midarm_gap");
    for (int x = 0; x < 8; x++)
      applyStimulus({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, W + x, "midarm_pix2");
    applyStimulus({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 0, "midarm_tail");
    checkValue("midarm_no_dval", dvalCount, 0);
    checkValue("midarm_no_sof", sofCount, 0);
    resetStats();
    runFrame(4, 8, 2, 1'b0, 1'b0, -1, 0);
    checkValue("midarm_first_x", firstX, 0);
    checkValue("midarm_first_y", firstY, 0);
    checkValue("midarm_next_dval", dvalCount, 32);

    $display("[TB] oversize frame");
    resetStats();
    runFrame(6, 10, 2, 1'b0, 1'b0, -1, 0);
    checkValue("oversize_dval_count", dvalCount, 32);
    checkValue("oversize_max_x", maxX, 7);
    checkValue("oversize_max_y", maxY, 3);
    checkValue("oversize_eof_count", eofCount, 1);

    $display("[TB] stop and mode latch");
    resetStats();
    runFrame(4, 8, 2, 1'b1, 1'b1, 1, 1);
    checkValue("stop_sw_stable", swBad, 0);
    checkValue("stop_sw_held", oSW, 1);
    checkValue("stop_eof_count", eofCount, 1);
    checkValue("stop_idle", oBusy, 0);
    resetStats();
    runFrame(4, 8, 2, 1'b0, 1'b0, -1, 0);
    checkValue("stop_next_no_dval", dvalCount, 0);
    checkValue("stop_next_no_sof", sofCount, 0);

    $display("[TB] mid-frame reset");
    applyStimulus({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 0, "midrst_start");
    resetStats();
    runFrame(4, 8, 2, 1'b1, 1'b0, 2, 2);
    checkValue("midrst_no_eof", eofCount, 0);
    checkValue("midrst_frame_cont", oFrame_Cont, 0);
    checkValue("midrst_idle", oBusy, 0);
    checkValue("midrst_outputs_zero", longint'({oDATA, oX_Cont, oY_Cont, oSW}), 0);

    $display("[TB] random run");
    f = 0;
    l = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) f = ~f;
      if ($urandom_range(0, 9) == 0) l = ~l;
      applyStimulus({($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 79) == 0), f, l, 1'($urandom)},
                    int'($urandom_range(0, 4095)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
